// File: rtl/keylock_ctrl.sv
// Keypad lock supervisor: assembles strobed BCD digits, checks them against the stored code,
// limits failed attempts with a timed lockout and auto-relocks. Optional macro: KEYLOCK_PROG_EN.
module keylock_ctrl #(
  parameter int          CODE_LEN    = 6,
  parameter logic [31:0] CODE        = 32'h00335256,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 1000,
  parameter int          UNLOCK_CYC  = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       relock,
  output logic       locked,
  output logic       lockout,
  output logic       busy,
  output logic [3:0] fail_count,
  output logic [3:0] digit_count
);

  localparam int TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam int EW   = CODE_LEN * 4;
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYC - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]    LEN4         = 4'(CODE_LEN);
  localparam logic [3:0]    MAXF4        = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    S_ENTRY    = 2'd0,
    S_CHECK    = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [EW-1:0] entry, entry_n;
  logic [3:0]    dcnt_n, fcnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [EW-1:0] stored_code;
  logic          is_digit;

  assign is_digit = (key <= 4'd9);

`ifdef KEYLOCK_PROG_EN
  logic [EW-1:0] code_reg, code_n, stage, stage_n;
  logic [3:0]    scnt, scnt_n;
  assign stored_code = code_reg;
`else
  assign stored_code = CODE[EW-1:0];
`endif

  always_comb begin
    state_n = state;
    entry_n = entry;
    dcnt_n  = digit_count;
    fcnt_n  = fail_count;
    timer_n = timer;
`ifdef KEYLOCK_PROG_EN
    code_n  = code_reg;
    stage_n = stage;
    scnt_n  = scnt;
`endif
    case (state)
      S_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            entry_n = {entry[EW-5:0], key};
            if (digit_count + 4'd1 == LEN4) begin
              state_n = S_CHECK;
              dcnt_n  = 4'd0;
            end else begin
              dcnt_n  = digit_count + 4'd1;
            end
          end else begin
            entry_n = '0;
            dcnt_n  = 4'd0;
          end
        end
      end
      S_CHECK: begin
        if (entry == stored_code) begin
          state_n = S_UNLOCKED;
          fcnt_n  = 4'd0;
          timer_n = UNLOCK_LOAD;
        end else if (fail_count + 4'd1 < MAXF4) begin
          state_n = S_ENTRY;
          fcnt_n  = fail_count + 4'd1;
        end else begin
          state_n = S_LOCKOUT;
          fcnt_n  = MAXF4;
          timer_n = LOCKOUT_LOAD;
        end
      end
      S_UNLOCKED: begin
        if (relock || timer == '0) begin
          state_n = S_ENTRY;
`ifdef KEYLOCK_PROG_EN
          stage_n = '0;
          scnt_n  = 4'd0;
`endif
        end else begin
          timer_n = timer - 1'b1;
`ifdef KEYLOCK_PROG_EN
          // A complete staged code becomes the new code and restarts the open window.
          if (key_valid) begin
            if (is_digit) begin
              if (scnt + 4'd1 == LEN4) begin
                code_n  = {stage[EW-5:0], key};
                timer_n = UNLOCK_LOAD;
                stage_n = '0;
                scnt_n  = 4'd0;
              end else begin
                stage_n = {stage[EW-5:0], key};
                scnt_n  = scnt + 4'd1;
              end
            end else begin
              stage_n = '0;
              scnt_n  = 4'd0;
            end
          end
`endif
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_ENTRY;
          fcnt_n  = 4'd0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = S_ENTRY;
    endcase
    // Any arrival in ENTRY from another state starts with an empty entry.
    if (state_n == S_ENTRY && state != S_ENTRY) begin
      entry_n = '0;
      dcnt_n  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_ENTRY;
      entry       <= '0;
      digit_count <= 4'd0;
      fail_count  <= 4'd0;
      timer       <= '0;
      locked      <= 1'b1;
      lockout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      entry       <= entry_n;
      digit_count <= dcnt_n;
      fail_count  <= fcnt_n;
      timer       <= timer_n;
      locked      <= (state_n != S_UNLOCKED);
      lockout     <= (state_n == S_LOCKOUT);
      busy        <= (state_n == S_CHECK);
    end
  end

`ifdef KEYLOCK_PROG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code_reg <= CODE[EW-1:0];
      stage    <= '0;
      scnt     <= 4'd0;
    end else begin
      code_reg <= code_n;
      stage    <= stage_n;
      scnt     <= scnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_keylock_ctrl.sv
// Directed bench for keylock_ctrl: an attempt/timer-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_keylock_ctrl;

  localparam int          CODE_LEN    = 6;
  localparam logic [31:0] CODE        = 32'h00335256;
  localparam int          MAX_FAIL    = 3;
  localparam int          LOCKOUT_CYC = 1000;
  localparam int          UNLOCK_CYC  = 500;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key;
  logic       relock;
  logic       locked, lockout, busy;
  logic [3:0] fail_count, digit_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  keylock_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(UNLOCK_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key(key), .relock(relock),
    .locked(locked), .lockout(lockout), .busy(busy),
    .fail_count(fail_count), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // ---------------- model: attempts, open window and lockout window in cycles
  int m_code[CODE_LEN];
  int m_dig[$];
  int m_stage[$];
  int m_fail;
  int m_open_left;
  int m_lock_left;
  bit m_check;

  function automatic void model_reset();
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(CODE[(CODE_LEN-1-i)*4 +: 4]);
    m_dig.delete();
    m_stage.delete();
    m_fail      = 0;
    m_open_left = 0;
    m_lock_left = 0;
    m_check     = 1'b0;
  endfunction

  function automatic bit code_matches();
    for (int i = 0; i < CODE_LEN; i++) if (m_dig[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
    end else if (m_check) begin
      m_check = 1'b0;
      if (code_matches()) begin
        m_open_left = UNLOCK_CYC;
        m_fail      = 0;
      end else begin
        m_fail = m_fail + 1;
        if (m_fail == MAX_FAIL) m_lock_left = LOCKOUT_CYC;
      end
      m_dig.delete();
    end else if (m_open_left > 0) begin
      if (relock || m_open_left == 1) begin
        m_open_left = 0;
        m_stage.delete();
      end else begin
        m_open_left = m_open_left - 1;
`ifdef KEYLOCK_PROG_EN
        if (key_valid) begin
          if (key <= 4'd9) begin
            m_stage.push_back(int'(key));
            if (m_stage.size() == CODE_LEN) begin
              for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_stage[i];
              m_stage.delete();
              m_open_left = UNLOCK_CYC;
            end
          end else begin
            m_stage.delete();
          end
        end
`endif
      end
    end else if (m_lock_left > 0) begin
      m_lock_left = m_lock_left - 1;
      if (m_lock_left == 0) m_fail = 0;
    end else if (key_valid) begin
      if (key <= 4'd9) begin
        m_dig.push_back(int'(key));
        if (m_dig.size() == CODE_LEN) m_check = 1'b1;
      end else begin
        m_dig.delete();
      end
    end
  end

  // ---------------- scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked",      32'(locked),      32'(m_open_left == 0));
      chk("lockout",     32'(lockout),     32'(m_lock_left > 0));
      chk("busy",        32'(busy),        32'(m_check));
      chk("fail_count",  32'(fail_count),  32'(m_fail));
      chk("digit_count", 32'(digit_count), m_check ? 32'd0 : 32'(m_dig.size()));
    end
  end

  // ---------------- driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobes n nibbles back-to-back, leftmost first; returns on the negedge after the last strobe.
  task automatic send(input logic [63:0] digs, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_valid = 1'b1;
      key       = digs[(n-1-i)*4 +: 4];
    end
    @(negedge clk);
    key_valid = 1'b0;
    key       = 4'd0;
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
  endtask

  // ---------------- directed stimulus
  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key       = 4'd0;
    relock    = 1'b0;
    model_reset();
    idle(3);
    chk_en  = 1'b1;
    chk("rst_locked", 32'(locked), 32'd1);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_digits", 32'(digit_count), 32'd0);
    reset_n = 1'b1;

    // Correct code: one CHECK cycle, then 500 open cycles, then relock by timer
    send(64'h335256, 6);
    chk("t1_busy", 32'(busy), 32'd1);
    idle(1);
    chk("t1_open_first", 32'(locked), 32'd0);
    chk("t1_busy_gone", 32'(busy), 32'd0);
    idle(UNLOCK_CYC - 1);
    chk("t1_open_last", 32'(locked), 32'd0);
    idle(1);
    chk("t1_relocked", 32'(locked), 32'd1);
    chk("t1_digits", 32'(digit_count), 32'd0);

    // Three wrong attempts -> lockout of exactly 1000 cycles, strobes ignored
    send(64'h335257, 6);
    idle(2);
    chk("t2_fail1", 32'(fail_count), 32'd1);
    send(64'h335257, 6);
    idle(2);
    chk("t2_fail2", 32'(fail_count), 32'd2);
    send(64'h335257, 6);
    idle(1);
    chk("t2_lockout_on", 32'(lockout), 32'd1);
    chk("t2_fail3", 32'(fail_count), 32'd3);
    send(64'h335256, 6);
    idle(LOCKOUT_CYC - 8);
    chk("t2_lockout_last", 32'(lockout), 32'd1);
    idle(1);
    chk("t2_lockout_off", 32'(lockout), 32'd0);
    chk("t2_fail_clear", 32'(fail_count), 32'd0);
    chk("t2_digits", 32'(digit_count), 32'd0);
    send(64'h335256, 6);
    idle(1);
    chk("t2_unlock", 32'(locked), 32'd0);

    // Relock on unlocked cycle 10; a digit strobe while open must not count
    idle(5);
    send(64'h9, 1);
    idle(2);
    pulse_relock();
    chk("t4_relock", 32'(locked), 32'd1);
    chk("t4_digits", 32'(digit_count), 32'd0);

    // CLEAR mid-entry, then full code; fail_count stays 0
    send(64'h33A335256, 9);
    idle(1);
    chk("t3_unlock", 32'(locked), 32'd0);
    chk("t3_fail", 32'(fail_count), 32'd0);
    pulse_relock();

    // Strobe landing on the CHECK cycle is lost
    send(64'h3352561, 7);
    chk("t6_open", 32'(locked), 32'd0);
    chk("t6_digits", 32'(digit_count), 32'd0);
    pulse_relock();

    // Reset mid-entry discards the partial entry
    send(64'h335, 3);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    send(64'h256, 3);
    idle(2);
    chk("t5_locked", 32'(locked), 32'd1);
    chk("t5_digits", 32'(digit_count), 32'd3);
    send(64'hA, 1);
    chk("t5_cleared", 32'(digit_count), 32'd0);

`ifdef KEYLOCK_PROG_EN
    send(64'h335256, 6);
    idle(1);
    chk("p_open", 32'(locked), 32'd0);
    send(64'h123456, 6);
    pulse_relock();
    send(64'h335256, 6);
    idle(1);
    chk("p_old_fails", 32'(locked), 32'd1);
    send(64'h123456, 6);
    idle(1);
    chk("p_new_opens", 32'(locked), 32'd0);
    pulse_relock();
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
